// File: rtl/cache_pkg.sv
// Shared cache constants and the miss-fill state type.
// Used by the fill controller and the cache data/tag arrays.
package cache_pkg;

  localparam int unsigned CACHE_ADDR_WIDTH = 16;
  localparam int unsigned CACHE_BLOCK_WORDS = 8;
  localparam int unsigned CACHE_OFF_W = $clog2(CACHE_BLOCK_WORDS);
  // Block base occupies address bits [ADDR_WIDTH-1:BLK_LSB]; bit 0 is the byte select.
  localparam int unsigned CACHE_BLK_LSB = CACHE_OFF_W + 1;
  localparam int unsigned CACHE_BLK_W = CACHE_ADDR_WIDTH - CACHE_BLK_LSB;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } fill_state_e;

endpackage

// File: rtl/fill_counter.sv
// Saturating up-counter with synchronous clear; o_done flags the count reaching Limit.
module fill_counter #(
  parameter int unsigned Width = 4,
  parameter int unsigned Limit = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [Width-1:0] o_cnt,
  output logic             o_done
);

  logic [Width-1:0] r_cnt;

  assign o_done = (r_cnt == Width'(Limit));
  assign o_cnt  = r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_done) begin
      r_cnt <= r_cnt + Width'(1);
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: streams one block of word reads to memory4c and writes
// the responses into the data array. Define FILL_STATS_EN for miss/stall counters.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = CACHE_ADDR_WIDTH,
  parameter int unsigned BLOCK_WORDS = CACHE_BLOCK_WORDS,
  localparam int unsigned OFF_W      = $clog2(BLOCK_WORDS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_miss_detected,
  input  logic [ADDR_WIDTH-1:0] i_miss_address,
  output logic                  o_fsm_busy,
  output logic                  o_mem_enable,
  output logic [ADDR_WIDTH-1:0] o_memory_address,
  input  logic                  i_memory_data_valid,
  input  logic [15:0]           i_memory_data,
  output logic                  o_write_data_array,
  output logic [OFF_W-1:0]      o_word_offset,
  output logic [15:0]           o_write_data,
`ifdef FILL_STATS_EN
  output logic [15:0]           o_miss_count,
  output logic [31:0]           o_stall_cycles,
`endif
  output logic                  o_write_tag_array
);

  localparam logic [OFF_W:0] LastIdx = (OFF_W + 1)'(BLOCK_WORDS - 1);

  fill_state_e                  r_state;
  fill_state_e                  w_state_next;
  logic [ADDR_WIDTH-1:OFF_W+1]  r_blk_base;
  logic [OFF_W:0]               w_issue_cnt;
  logic [OFF_W:0]               w_rx_cnt;
  logic                         w_issue_done;
  logic                         w_rx_done;
  logic                         w_cnt_clr;
  logic                         w_issue_en;
  logic                         w_rx_en;

  fill_counter #(
    .Width (OFF_W + 1),
    .Limit (BLOCK_WORDS)
  ) u_issue_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_cnt_clr),
    .i_en   (w_issue_en),
    .o_cnt  (w_issue_cnt),
    .o_done (w_issue_done)
  );

  fill_counter #(
    .Width (OFF_W + 1),
    .Limit (BLOCK_WORDS)
  ) u_rx_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_cnt_clr),
    .i_en   (w_rx_en),
    .o_cnt  (w_rx_cnt),
    .o_done (w_rx_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_blk_base <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StIdle && i_miss_detected) begin
        r_blk_base <= i_miss_address[ADDR_WIDTH-1:OFF_W+1];
      end
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_cnt_clr          = 1'b0;
    w_issue_en         = 1'b0;
    w_rx_en            = 1'b0;
    o_fsm_busy         = 1'b0;
    o_mem_enable       = 1'b0;
    o_memory_address   = '0;
    o_write_data_array = 1'b0;
    o_word_offset      = '0;
    o_write_data       = '0;
    o_write_tag_array  = 1'b0;

    unique case (r_state)
      StIdle: begin
        // Counters sit cleared while idle so a new fill always starts at word 0.
        w_cnt_clr = 1'b1;
        if (i_miss_detected) begin
          w_state_next = StIssue;
        end
      end
      StIssue: begin
        o_fsm_busy       = 1'b1;
        o_mem_enable     = 1'b1;
        o_memory_address = {r_blk_base, w_issue_cnt[OFF_W-1:0], 1'b0};
        w_issue_en       = !w_issue_done;
        if (w_issue_cnt == LastIdx) begin
          w_state_next = StDrain;
        end
      end
      StDrain: begin
        o_fsm_busy = 1'b1;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase

    // Responses return in issue order, so the receive count is the word index.
    if (r_state != StIdle && i_memory_data_valid && !w_rx_done) begin
      o_write_data_array = 1'b1;
      o_word_offset      = w_rx_cnt[OFF_W-1:0];
      o_write_data       = i_memory_data;
      w_rx_en            = 1'b1;
      if (w_rx_cnt == LastIdx) begin
        o_write_tag_array = 1'b1;
        w_state_next      = StIdle;
      end
    end
  end

`ifdef FILL_STATS_EN
  logic [15:0] r_miss_count;
  logic [31:0] r_stall_cycles;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_miss_count   <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (r_state == StIdle && w_state_next == StIssue) begin
        r_miss_count <= r_miss_count + 16'd1;
      end
      if (o_fsm_busy) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
    end
  end

  assign o_miss_count   = r_miss_count;
  assign o_stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: a 4-cycle memory pipe returning data = address, and a
// count-based reference model of one block fill. Checks stats ports when FILL_STATS_EN.
module tb_cache_fill_fsm;

  localparam int unsigned BW  = 8;
  localparam int unsigned LAT = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_miss_detected;
  logic [15:0] i_miss_address;
  logic        o_fsm_busy;
  logic        o_mem_enable;
  logic [15:0] o_memory_address;
  logic        i_memory_data_valid;
  logic [15:0] i_memory_data;
  logic        o_write_data_array;
  logic [2:0]  o_word_offset;
  logic [15:0] o_write_data;
  logic        o_write_tag_array;
`ifdef FILL_STATS_EN
  logic [15:0] o_miss_count;
  logic [31:0] o_stall_cycles;
`endif

  cache_fill_fsm u_dut (
    .i_clk               (i_clk),
    .i_rst               (i_rst),
    .i_miss_detected     (i_miss_detected),
    .i_miss_address      (i_miss_address),
    .o_fsm_busy          (o_fsm_busy),
    .o_mem_enable        (o_mem_enable),
    .o_memory_address    (o_memory_address),
    .i_memory_data_valid (i_memory_data_valid),
    .i_memory_data       (i_memory_data),
    .o_write_data_array  (o_write_data_array),
    .o_word_offset       (o_word_offset),
    .o_write_data        (o_write_data),
`ifdef FILL_STATS_EN
    .o_miss_count        (o_miss_count),
    .o_stall_cycles      (o_stall_cycles),
`endif
    .o_write_tag_array   (o_write_tag_array)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Memory pipe: request in cycle n returns in cycle n+LAT.
  logic        pv[LAT];
  logic [15:0] pa[LAT];
  logic [15:0] arr[BW];

  // Reference model: one fill = BW issues, BW in-order responses.
  bit          m_busy;
  int          m_issued;
  int          m_recv;
  logic [15:0] m_base;
  int          m_start;
  int          m_miss;
  int          m_stall;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input logic rst, input logic miss, input logic [15:0] addr,
                      input logic stray, input logic [15:0] stray_data);
    logic        exp_en, exp_wr, exp_tag, stray_eff, req_v;
    logic [15:0] exp_addr, exp_wdata, req_a;
    logic [2:0]  exp_off;
    stray_eff = stray && !m_busy && !pv[LAT-1];
    i_rst = rst;
    i_miss_detected = miss;
    i_miss_address = addr;
    i_memory_data_valid = pv[LAT-1] | stray_eff;
    i_memory_data = pv[LAT-1] ? pa[LAT-1] : stray_data;
    #1;
    exp_en    = m_busy && (m_issued < BW);
    exp_addr  = exp_en ? m_base + 16'(2 * m_issued) : 16'h0;
    exp_wr    = m_busy && i_memory_data_valid && (m_recv < BW);
    exp_off   = exp_wr ? 3'(m_recv) : 3'd0;
    exp_wdata = exp_wr ? m_base + 16'(2 * m_recv) : 16'h0;
    exp_tag   = exp_wr && (m_recv == BW - 1);
    check_eq("busy", 32'(o_fsm_busy), 32'(m_busy));
    check_eq("mem_enable", 32'(o_mem_enable), 32'(exp_en));
    check_eq("mem_addr", 32'(o_memory_address), 32'(exp_addr));
    check_eq("wr_data_array", 32'(o_write_data_array), 32'(exp_wr));
    check_eq("word_offset", 32'(o_word_offset), 32'(exp_off));
    check_eq("write_data", 32'(o_write_data), 32'(exp_wdata));
    check_eq("wr_tag_array", 32'(o_write_tag_array), 32'(exp_tag));
`ifdef FILL_STATS_EN
    check_eq("miss_count", 32'(o_miss_count), 32'(m_miss));
    check_eq("stall_cycles", o_stall_cycles, 32'(m_stall));
`endif
    if (o_write_data_array) arr[o_word_offset] = o_write_data;
    if (o_write_tag_array) begin
      check_eq("tag_latency", 32'(cyc - m_start), 32'd12);
      for (int k = 0; k < BW; k++) begin
        check_eq($sformatf("array_w%0d", k), 32'(arr[k]), 32'(m_base | 16'(k << 1)));
      end
    end
    req_v = o_mem_enable;
    req_a = o_memory_address;

    // Model update for the coming edge.
    if (rst) begin
      m_busy = 0; m_issued = 0; m_recv = 0; m_miss = 0; m_stall = 0;
    end else if (!m_busy) begin
      if (miss) begin
        m_busy = 1; m_issued = 0; m_recv = 0;
        m_base = addr & 16'hFFF0;
        m_start = cyc;
        m_miss = (m_miss + 1) % 65536;
      end
    end else begin
      m_stall++;
      if (m_issued < BW) m_issued++;
      if (exp_wr) begin
        m_recv++;
        if (m_recv == BW) m_busy = 0;
      end
    end

    @(posedge i_clk);
    for (int k = LAT - 1; k > 0; k--) begin
      pv[k] = rst ? 1'b0 : pv[k-1];
      pa[k] = pa[k-1];
    end
    pv[0] = rst ? 1'b0 : req_v;
    pa[0] = req_a;
    @(negedge i_clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  initial begin
    for (int k = 0; k < LAT; k++) begin pv[k] = 1'b0; pa[k] = 16'h0; end
    for (int k = 0; k < BW; k++) arr[k] = 16'h0;
    m_busy = 0; m_issued = 0; m_recv = 0; m_base = 16'h0; m_start = 0;
    m_miss = 0; m_stall = 0;
    i_rst = 1'b1; i_miss_detected = 1'b0; i_miss_address = 16'h0;
    i_memory_data_valid = 1'b0; i_memory_data = 16'h0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);

    // Reset state, then a single fill.
    idle(2);
    step(1'b0, 1'b1, 16'h1236, 1'b0, 16'h0);
    idle(14);

    // Miss held through the fill, then a back-to-back miss in cycle 13.
    for (int i = 0; i < 13; i++) step(1'b0, 1'b1, 16'h1236, 1'b0, 16'h0);
    step(1'b0, 1'b1, 16'hA000, 1'b0, 16'h0);
    check_eq("b2b_first_addr", 32'(o_memory_address), 32'hA000);
    idle(14);
`ifdef FILL_STATS_EN
    check_eq("stats_miss3", 32'(o_miss_count), 32'd3);
    check_eq("stats_stall36", o_stall_cycles, 32'd36);
`endif

    // Reset in cycle 7 of a fill, then a clean fill.
    step(1'b0, 1'b1, 16'h2468, 1'b0, 16'h0);
    idle(6);
    step(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    check_eq("rst_busy", 32'(o_fsm_busy), 32'd0);
    check_eq("rst_mem_en", 32'(o_mem_enable), 32'd0);
    idle(3);
    step(1'b0, 1'b1, 16'h555E, 1'b0, 16'h0);
    idle(14);

    // Stray valids while idle.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0, 1'b1, 16'hBEEF);
    check_eq("stray_no_busy", 32'(o_fsm_busy), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0), 16'($urandom),
           ($urandom_range(0, 5) == 0), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
Miss-handling controller that sits directly upstream of the 4-cycle pipelined main memory (memory4c). On a cache miss it issues back-to-back word reads for the whole 16-byte block and collects the data_valid-tagged responses. It streams each returned word into the cache data array, then writes the tag. It holds the pipeline via fsm_busy until the block is resident.

Parameters:
ADDR_WIDTH, 16, byte-address width shared with memory4c.
BLOCK_WORDS, 8, 16-bit words per cache block (power of two; offset width OFF_W = log2(BLOCK_WORDS)).

Ports:
clk  in  1  system clock, all state on rising edge.
rst  in  1  synchronous, active-high reset.
miss_detected  in  1  cache lookup missed this cycle.
miss_address  in  ADDR_WIDTH  byte address of the missing access.
fsm_busy  out  1  fill in progress; stall requester.
mem_enable  out  1  read request to memory (memory wr tied 0 by parent).
memory_address  out  ADDR_WIDTH  word-aligned read address.
memory_data_valid  in  1  memory response valid (memory4c data_valid).
memory_data  in  16  memory response data.
write_data_array  out  1  write one word into cache data array.
word_offset  out  OFF_W  word index within block for that write.
write_data  out  16  word to write (= memory_data).
write_tag_array  out  1  one-cycle tag/valid write pulse.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- States: IDLE, ISSUE, DRAIN. Registers: state, blk_base[ADDR_WIDTH-1:OFF_W+1], issue_cnt[OFF_W:0], rx_cnt[OFF_W:0].
- Reset: state=IDLE, counters=0, blk_base=0. All outputs are 0 in the cycle after rst is sampled high.
- IDLE: on miss_detected, latch miss_address upper bits into blk_base, clear counters, go to ISSUE. fsm_busy=0 in IDLE (registered busy; the requester already stalls on its own miss signal).
- ISSUE: mem_enable=1 every cycle. memory_address={blk_base, issue_cnt[OFF_W-1:0], 1'b0}. issue_cnt increments each cycle. After BLOCK_WORDS issues, go to DRAIN. No bubbles between issues.
- Response path (ISSUE or DRAIN): when memory_data_valid=1, assert write_data_array=1, word_offset=rx_cnt, write_data=memory_data, and rx_cnt increments. Responses arrive in issue order and carry no tag; rx_cnt is the sole index.
- Last response (rx_cnt==BLOCK_WORDS-1 with valid): write_tag_array=1 in that same cycle. Next state is IDLE.
- fsm_busy=1 in ISSUE and DRAIN.
- Timing with memory latency 4: miss seen cycle 0; issues cycles 1-8; valids cycles 5-12; tag write cycle 12; busy cycles 1-12; IDLE cycle 13.
- Back-to-back misses: a miss_detected in cycle 13 starts a new fill immediately.
- miss_detected while busy: ignored; the miss address is not re-latched.
- memory_data_valid in IDLE: ignored; no array writes.
- Excess valids after the final word: impossible by construction. rx_cnt saturates and the extras are ignored.
- rst mid-fill: abort immediately to IDLE with no tag write. Partially written data words are left unvalidated. Memory pipeline is flushed by the same rst.
- Counters are OFF_W+1 bits wide so that completion is reached without wrap aliasing.

Optional Feature:
FILL_STATS_EN: when defined, adds output ports miss_count[15:0] and stall_cycles[31:0].
- miss_count increments on each IDLE->ISSUE transition.
- stall_cycles increments every cycle fsm_busy=1.
- Both counters wrap silently and clear on rst.
When the macro is undefined, the ports and registers are absent and the rest of the behaviour is identical.

Decomposition:
- Package cache_pkg: fill-state enum (IDLE, ISSUE, DRAIN), BLOCK_WORDS, OFF_W, and the block-base slice constants, shared with the cache array and tag modules.
- One natural sub-module: fill_counter, an OFF_W+1-bit up-counter with clear, enable and a done flag. It is instantiated twice, for the issue and receive counts.

Test Plan:
- Single miss at 0x1236 with a memory4c model -> addresses 0x1230,0x1232,...,0x123E on cycles 1-8; write_data_array on cycles 5-12 with offsets 0-7; write_tag_array only on cycle 12; busy cycles 1-12.
- Miss held high for the whole fill at 0x1236, then a second miss at 0xA000 in cycle 13 -> no re-latch during the fill; second fill issues 0xA000 in cycle 14.
- rst asserted in cycle 7 of a fill -> cycle 8: IDLE, mem_enable=0, busy=0; no tag write ever; next miss fills cleanly.
- Stray memory_data_valid pulse while IDLE -> no write_data_array, no state change.
- Responses with memory data = address -> the cache array word at offset k equals blk_base|k<<1 for every k.
- FILL_STATS_EN with 3 fills -> miss_count=3, stall_cycles=36.
